freq_meter: RTL and testbench



---
 rtl/freq_meter.sv | 147 ++++++++++++++
 tb/tb_freq_meter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: gated-window frequency meter.
//
// Counts rising edges of an asynchronous input over a window of GATE_CYCLES
// clk cycles. At the end of each window the result is latched into count and
// overflow, and valid pulses for one cycle. With continuous held high, windows
// run back to back with no dead cycle between them.
//
// Ports:
//   clk        system clock; all state updates on posedge
//   rst_n      asynchronous, active-low reset
//   start      single-shot request, sampled only while idle
//   continuous 1 = back-to-back windows
//   sig_in     asynchronous signal under measurement
//   count      rising edges counted in the last completed window
//   valid      one-cycle pulse when count/overflow update
//   busy       1 while a window is in progress
//   overflow   last window saturated the edge counter
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 100000000,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             continuous,
    input  logic             sig_in,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             busy,
    output logic             overflow
);

    localparam logic [31:0]      GATE_LAST = 32'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {
        IDLE,
        GATE
    } state_t;

    // Saturating increment: the edge counter sticks at its maximum value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             inc);
        if (inc && (v != CNT_MAX)) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    logic             s1_q, s2_q, s3_q;
    state_t           state_q, state_d;
    logic [31:0]      gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;

    logic             rise;
    logic [CNT_W-1:0] edge_nxt;
    logic             sat_hit;

    // Input stage: two-flop synchronizer then a delay flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise     = s2_q & ~s3_q;
    assign edge_nxt = sat_inc(edge_cnt_q, rise);
    assign sat_hit  = rise && (edge_cnt_q == CNT_MAX);

    // Window control and result latching.
    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start || continuous) begin
                    state_d    = GATE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end
            end
            GATE: begin
                if (gate_cnt_q == GATE_LAST) begin
                    // A rise on the last cycle belongs to this window; the
                    // next window starts clean so nothing is counted twice.
                    count_d    = edge_nxt;
                    overflow_d = sat_q | sat_hit;
                    valid_d    = 1'b1;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                    if (!continuous) begin
                        state_d = IDLE;
                    end
                end else begin
                    gate_cnt_d = gate_cnt_q + 32'd1;
                    edge_cnt_d = edge_nxt;
                    sat_d      = sat_q | sat_hit;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;
    assign busy     = (state_q == GATE);

endmodule

// File: tb/tb_freq_meter.sv
// Testbench for freq_meter. Three instances share clock, reset and sig_in:
//   a: GATE_CYCLES=100, CNT_W=32 (single-shot, re-start, reset abort)
//   b: GATE_CYCLES=100, CNT_W=4  (saturation / overflow)
//   c: GATE_CYCLES=50,  CNT_W=32 (continuous mode)
// Expected results are queued when a window is launched and popped when the
// matching instance pulses valid.
module tb_freq_meter;

    typedef struct {
        logic [31:0] cnt;
        logic        ovf;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sig_in = 1'b0;
    logic        start_a, start_b, start_c;
    logic        cont_a, cont_b, cont_c;
    logic [31:0] count_a, count_c;
    logic [3:0]  count_b;
    logic        valid_a, valid_b, valid_c;
    logic        busy_a, busy_b, busy_c;
    logic        ovf_a, ovf_b, ovf_c;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   per = 0;
    logic hold = 1'b0;
    int   ph = 0;
    exp_t q[3][$];

    freq_meter #(.GATE_CYCLES(100), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .continuous(cont_a),
        .sig_in(sig_in), .count(count_a), .valid(valid_a), .busy(busy_a),
        .overflow(ovf_a)
    );

    freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .continuous(cont_b),
        .sig_in(sig_in), .count(count_b), .valid(valid_b), .busy(busy_b),
        .overflow(ovf_b)
    );

    freq_meter #(.GATE_CYCLES(50), .CNT_W(32)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .continuous(cont_c),
        .sig_in(sig_in), .count(count_c), .valid(valid_c), .busy(busy_c),
        .overflow(ovf_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic score(input int k, input logic [31:0] cnt, input logic ovf);
        exp_t e;
        chk($sformatf("%0d_valid_expected", k), 32'(q[k].size() != 0), 32'd1);
        if (q[k].size() != 0) begin
            e = q[k].pop_front();
            chk($sformatf("%0d_count", k), cnt, e.cnt);
            chk($sformatf("%0d_overflow", k), 32'(ovf), 32'(e.ovf));
            chk($sformatf("%0d_valid_time", k), 32'(cyc), 32'(e.t));
        end
    endtask

    task automatic push(input int k, input logic [31:0] cnt, input logic ovf, input int t);
        exp_t e;
        e.cnt = cnt;
        e.ovf = ovf;
        e.t   = t;
        q[k].push_back(e);
    endtask

    task automatic pulse(input int k);
        if (k == 0) start_a = 1'b1;
        else if (k == 1) start_b = 1'b1;
        else start_c = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stimulus generator: period per clk cycles (high for per/2), or a held level.
    initial begin
        forever begin
            @(negedge clk);
            if (per == 0) begin
                sig_in = hold;
            end else begin
                ph     = (ph + 1) % per;
                sig_in = (ph < per / 2);
            end
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_a) score(0, count_a, ovf_a);
            if (valid_b) score(1, 32'(count_b), ovf_b);
            if (valid_c) score(2, count_c, ovf_c);
        end
    end

    initial begin
        int c;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        cont_a  = 1'b0;
        cont_b  = 1'b0;
        cont_c  = 1'b0;

        wait_cyc(3);
        chk("rst_count", count_a, 32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_overflow", 32'(ovf_a), 32'd0);
        rst_n = 1'b1;
        wait_cyc(2);

        // Single window, period 10 -> 10 edges; busy for exactly 100 cycles.
        per = 10;
        wait_cyc(20);
        c = cyc;
        push(0, 32'd10, 1'b0, c + 101);
        pulse(0);
        chk("t1_busy_first", 32'(busy_a), 32'd1);
        wait_cyc(99);
        chk("t1_busy_last", 32'(busy_a), 32'd1);
        wait_cyc(1);
        chk("t1_busy_done", 32'(busy_a), 32'd0);
        wait_cyc(5);

        // Held high for the whole window -> no edges.
        per  = 0;
        hold = 1'b1;
        wait_cyc(20);
        c = cyc;
        push(0, 32'd0, 1'b0, c + 101);
        pulse(0);
        wait_cyc(110);

        // 4-bit counter, period 4 -> 25 edges saturate at 15.
        per = 4;
        wait_cyc(20);
        c = cyc;
        push(1, 32'd15, 1'b1, c + 101);
        pulse(1);
        wait_cyc(105);
        // Following window at period 10 clears overflow.
        per = 10;
        wait_cyc(20);
        c = cyc;
        push(1, 32'd10, 1'b0, c + 101);
        pulse(1);
        wait_cyc(105);

        // Continuous windows of 50 at period 5; drop continuous mid-4th window.
        per = 5;
        wait_cyc(20);
        c = cyc;
        for (int i = 1; i <= 4; i++) push(2, 32'd10, 1'b0, c + 1 + 50 * i);
        cont_c = 1'b1;
        wait_cyc(175);
        cont_c = 1'b0;
        wait_cyc(25);
        chk("t4_busy_before_end", 32'(busy_c), 32'd1);
        wait_cyc(1);
        chk("t4_busy_after_end", 32'(busy_c), 32'd0);
        wait_cyc(60);
        chk("t4_busy_stays_idle", 32'(busy_c), 32'd0);

        // start re-pulsed at cycle 30 of a window is ignored.
        per = 10;
        wait_cyc(20);
        c = cyc;
        push(0, 32'd10, 1'b0, c + 101);
        pulse(0);
        wait_cyc(29);
        pulse(0);
        wait_cyc(120);
        chk("t5_count_hold", count_a, 32'd10);

        // Reset at cycle 40 of a window aborts it.
        pulse(0);
        wait_cyc(39);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_count", count_a, 32'd0);
        chk("t6_rst_valid", 32'(valid_a), 32'd0);
        chk("t6_rst_busy", 32'(busy_a), 32'd0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(5);
        c = cyc;
        push(0, 32'd10, 1'b0, c + 101);
        pulse(0);
        wait_cyc(120);

        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%0d_pending_at_end", k), 32'(q[k].size()), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
